fetch_unit: RTL and testbench

Instruction-fetch front end that consumes next-PC redirects from the Npc stage and turns them into a stream of instruction-memory requests. It owns the architectural fetch PC, issues in-order word reads to instruction memory, buffers up to two returned words, and presents them with their PC to the IF/ID register under a valid/ready handshake. On a redirect (branch, jump, jal, jr) it discards stale buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end: owns the fetch PC, issues in-order
//             word reads and buffers up to two returned words for IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:2] redirect_pc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:2] inst_pc,
    input  logic        inst_ready
);

    localparam logic [31:2] c_RESET_WORD = RESET_PC[31:2];

    logic [31:2] fetch_pc_q, fetch_pc_d;
    logic [31:2] resp_pc_q,  resp_pc_d;   // pc of the next word that will be kept
    logic [1:0]  live_q,     live_d;
    logic [1:0]  drop_q,     drop_d;
    logic [1:0]  cnt_q,      cnt_d;
    logic        wr_ptr_q,   wr_ptr_d;
    logic        rd_ptr_q,   rd_ptr_d;
    logic [31:2] slot_pc_q   [2];
    logic [31:0] slot_inst_q [2];

    logic [2:0]  w_outstanding;
    logic [2:0]  w_live_buf;
    logic        w_issue;
    logic        w_keep;
    logic        w_discard;
    logic        w_push;
    logic        w_pop;

    // Credit checks use registered counts only; a same-cycle pop does not free a slot.
    assign w_outstanding = {1'b0, live_q} + {1'b0, drop_q};
    assign w_live_buf    = {1'b0, live_q} + {1'b0, cnt_q};

    assign imem_req   = !rst && !redirect_valid && (w_outstanding < 3'd2) && (w_live_buf < 3'd2);
    assign imem_addr  = fetch_pc_q;
    assign w_issue    = imem_req && imem_gnt;
    assign w_keep     = imem_rvalid && (drop_q == 2'd0);
    assign w_discard  = imem_rvalid && (drop_q != 2'd0);
    assign w_push     = !redirect_valid && w_keep;

    assign inst_valid = (cnt_q != 2'd0);
    assign w_pop      = inst_valid && inst_ready;
    assign inst       = inst_valid ? slot_inst_q[rd_ptr_q] : 32'd0;
    assign inst_pc    = inst_valid ? slot_pc_q[rd_ptr_q]   : 30'd0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a word landing now is already one of them.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            live_d     = 2'd0;
            drop_d     = drop_q + live_q - {1'b0, imem_rvalid};
            cnt_d      = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + 30'd1;
            end
            live_d = live_q + {1'b0, w_issue} - {1'b0, w_keep};
            drop_d = drop_q - {1'b0, w_discard};
            if (w_keep) begin
                wr_ptr_d  = ~wr_ptr_q;
                resp_pc_d = resp_pc_q + 30'd1;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, w_keep} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q     <= c_RESET_WORD;
            resp_pc_q      <= c_RESET_WORD;
            live_q         <= 2'd0;
            drop_q         <= 2'd0;
            cnt_q          <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            slot_pc_q[0]   <= 30'd0;
            slot_pc_q[1]   <= 30'd0;
            slot_inst_q[0] <= 32'd0;
            slot_inst_q[1] <= 32'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (w_push) begin
                slot_pc_q[wr_ptr_q]   <= resp_pc_q;
                slot_inst_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Randomized scoreboard bench for fetch_unit with a queued
//             instruction-memory model and an expected-PC-stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [29:0] c_RESET_WORD = 30'h0000_0C00;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic [29:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [29:0] exp_q[$];
    logic [29:0] exp_next;
    int          last_due;
    logic        redir_seen;

    int cyc    = 0;
    int pops   = 0;
    int d_cmp  = 0;
    int d_fail = 0;
    int m_cmp  = 0;
    int m_fail = 0;

    int          gnt_pct   = 100;
    int          ready_pct = 100;
    int          redir_pct = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    logic        force_redir = 1'b0;
    logic [29:0] force_pc    = 30'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        d_cmp++;
        if (act !== exp) begin
            d_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        m_cmp++;
        if (act !== exp) begin
            m_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: memory bookkeeping plus comparison of every delivered instruction.
    always @(negedge clk) begin
        int n_before;
        int due;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_next   = c_RESET_WORD;
            last_due   = 0;
            redir_seen = 1'b0;
            while (exp_q.size() < 4) begin exp_q.push_back(exp_next); exp_next = exp_next + 30'd1; end
        end else begin
            if (redir_seen) mchk("flush_after_redirect", 32'(inst_valid), 32'd0);
            if (!inst_valid) begin
                mchk("empty_inst", inst, 32'd0);
                mchk("empty_pc", 32'(inst_pc), 32'd0);
            end
            n_before = mem_q.size();
            if (imem_rvalid) begin
                m_cmp++;
                if (n_before == 0) begin
                    m_fail++;
                    $display("FAIL rvalid_without_request: got rvalid expected none outstanding");
                end else begin
                    void'(mem_q.pop_front());
                end
            end
            if (imem_req) mchk("req_during_redirect", 32'(redirect_valid), 32'd0);
            if (imem_req && imem_gnt) begin
                mchk("outstanding_limit", 32'(n_before < 2), 32'd1);
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: imem_addr, due: due});
            end
            if (inst_valid && inst_ready) begin
                mchk("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
                mchk("inst_word", inst, word_of(exp_q[0]));
                void'(exp_q.pop_front());
                pops++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_next = redirect_pc;
            end
            while (exp_q.size() < 4) begin exp_q.push_back(exp_next); exp_next = exp_next + 30'd1; end
            redir_seen = redirect_valid;
        end
    end

    task automatic step();
        logic [31:0] r;
        @(posedge clk); #1;
        imem_gnt       = (int'($urandom_range(0, 99)) < gnt_pct);
        inst_ready     = (int'($urandom_range(0, 99)) < ready_pct);
        redirect_valid = 1'b0;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if (int'($urandom_range(0, 99)) < redir_pct) begin
            r              = $urandom;
            redirect_valid = 1'b1;
            redirect_pc    = (r[31:30] == 2'b00) ? 30'h3FFF_FFFE : r[29:0];
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mem_q[0].addr);
        end else begin
            r           = $urandom;
            imem_rvalid = 1'b0;
            imem_rdata  = r;
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b1;
        inst_ready     = 1'b1;
        #1;
        dchk("req_after_reset", 32'(imem_req), 32'd1);
        dchk("addr_after_reset", 32'(imem_addr), 32'(c_RESET_WORD));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  p0;
        logic hit;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 30'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dchk("reset_req", 32'(imem_req), 32'd0);
        dchk("reset_valid", 32'(inst_valid), 32'd0);
        dchk("reset_inst", inst, 32'd0);
        dchk("reset_pc", 32'(inst_pc), 32'd0);

        // Startup latency: issue in cycle 0, word visible in cycle 2.
        release_reset();
        @(negedge clk); dchk("startup_valid_c0", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk); dchk("startup_valid_c1", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk);
        dchk("startup_valid_c2", 32'(inst_valid), 32'd1);
        dchk("startup_pc_c2", 32'(inst_pc), 32'(c_RESET_WORD));

        p0 = pops;
        repeat (30) step();
        @(negedge clk);
        dchk("stream_progress", 32'(pops - p0 >= 18), 32'd1);

        ready_pct = 0;
        repeat (6) step();
        @(negedge clk);
        dchk("backpressure_req", 32'(imem_req), 32'd0);
        dchk("backpressure_valid", 32'(inst_valid), 32'd1);
        ready_pct = 100;
        p0 = pops;
        repeat (10) step();
        dchk("backpressure_drain", 32'(pops - p0 >= 6), 32'd1);

        // Redirect while two long-latency fetches are outstanding.
        lat_min = 3; lat_max = 3;
        repeat (8) step();
        force_pc = 30'h0000_0C40; force_redir = 1'b1;
        step();
        @(negedge clk); dchk("redirect_flush", 32'(inst_valid), 32'd0);
        p0 = pops;
        repeat (15) step();
        dchk("redirect_progress", 32'(pops - p0 >= 2), 32'd1);

        // Redirect coinciding with a pop and a returning word.
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (inst_valid && inst_ready && imem_rvalid) begin
                redirect_valid = 1'b1;
                redirect_pc    = 30'h0000_0D00;
                hit            = 1'b1;
            end
        end
        dchk("simultaneous_reached", 32'(hit), 32'd1);
        step();
        #1; dchk("simultaneous_empty", 32'(inst_valid), 32'd0);
        repeat (10) step();

        gnt_pct = 70; ready_pct = 70; redir_pct = 4; lat_min = 1; lat_max = 3;
        p0 = pops;
        repeat (2000) step();
        dchk("random_progress", 32'(pops - p0 > 300), 32'd1);

        // Asynchronous reset with a full buffer.
        gnt_pct = 100; ready_pct = 0; redir_pct = 0; lat_min = 1; lat_max = 1;
        repeat (8) step();
        #2;
        dchk("full_before_reset", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        #1;
        dchk("async_valid", 32'(inst_valid), 32'd0);
        dchk("async_req", 32'(imem_req), 32'd0);
        dchk("async_addr", 32'(imem_addr), 32'(c_RESET_WORD));
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        ready_pct = 100;
        p0 = pops;
        repeat (20) step();
        dchk("restart_progress", 32'(pops - p0 >= 10), 32'd1);

        repeat (5) step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", d_cmp + m_cmp, d_fail + m_fail);
        $finish;
    end

endmodule
`default_nettype wire
